qm_minterm_scanner: RTL and testbench
=====================================

Name: qm_minterm_scanner

Overview:
- Sequential successor to the team's fixed gate-level test circuits: a parametrised engine that holds a programmable sum-of-products function.
- Function is up to N_TERMS cubes over N_IN inputs.
- Sweeps all 2^N_IN input vectors in ascending order and streams out every ON-set minterm over a valid/ready handshake.
- Feeds the Quine-McCluskey lab hardware flow as the minterm source, replacing hand-expanded truth tables.

Parameters:
- N_IN, 13, number of function inputs (1..16)
- N_TERMS, 16, number of cube slots in the term table
- IDX_W, $clog2(N_TERMS), term index width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  term write request
- load_ready  out  1  term table writable (IDLE only)
- load_idx  in  IDX_W  slot to write
- load_mask  in  N_IN  cube care mask (1 = literal present)
- load_val  in  N_IN  cube literal polarity for cared bits
- load_en  in  1  slot enable written with the cube
- start  in  1  begin scan (IDLE only)
- abort  in  1  cancel scan
- busy  out  1  high in SCAN or FLUSH
- done  out  1  one-cycle pulse at scan completion
- m_valid  out  1  minterm available
- m_ready  in  1  consumer accepts minterm
- m_vec  out  N_IN  minterm value
- m_count  out  N_IN+1  minterms accepted in current/last scan

Behaviour:
- Reset (async on rst_n low): state IDLE; all table enables 0; vec 0; m_valid 0; m_vec 0; m_count 0; done 0; busy 0; load_ready 1 after release.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - load_ready=1; load_valid writes {mask,val,en} to slot load_idx on the same edge.
  - start → SCAN with vec=0 and m_count=0.
  - If load_valid and start are high together, the write completes and the scan uses the new table.
- Term match: slot hits when en & (((vec ^ val) & mask) == 0). f(vec) = OR of all hits.
  - An enabled slot with mask=0 is constant 1.
  - No enabled slots gives f=0 everywhere.
- SCAN:
  - Single output register. Stall when m_valid & !m_ready.
  - When not stalled: if f(vec), load m_vec<=vec and m_valid<=1. Otherwise m_valid<=0, or stays 1 only if a new hit loads.
  - vec increments when not stalled.
  - Latency: vec evaluated on edge k appears on m_vec after edge k.
  - m_count increments on each m_valid & m_ready handshake.
  - After evaluating vec = 2^N_IN-1 → FLUSH. vec does not wrap into a second pass.
- FLUSH: hold until m_valid=0 (last beat accepted), then → DONE.
- DONE: done=1 for exactly one cycle → IDLE. m_count holds its final value until the next start.
- abort in SCAN or FLUSH:
  - Next edge → IDLE, m_valid<=0; pending beat dropped and not counted; no done pulse.
  - abort wins over a simultaneous handshake.
  - abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. load_valid outside IDLE is ignored (load_ready=0).
- m_vec and m_valid stay stable while stalled.
- Minimum scan length is 2^N_IN cycles plus stall cycles.

Optional Feature:
- Macro QM_DONTCARE_EN.
- Defined:
  - Adds per-slot dc bit, port load_dc (in, 1), and output m_dc (out, 1).
  - dc slots form the don't-care set D; non-dc slots form the ON set.
  - Vectors in D but not in ON are emitted with m_dc=1.
  - Vectors in ON are emitted with m_dc=0 (ON has priority).
  - m_count counts only m_dc=0 beats.
- Undefined: ports absent; every enabled slot is ON.

Decomposition:
- Package qm_scan_pkg:
  - cube_t struct {mask, val, en, dc} parametrised via N_IN localparam.
  - state_t enum {IDLE, SCAN, FLUSH, DONE}.
  - Helper function cube_hit(cube_t, vec).
- Sub-module qm_cube_match: purely combinational, takes term table + vec, returns on_hit and dc_hit.
- Top holds FSM, table registers, vec counter, output register.

Test Plan (N_IN=4, N_TERMS=4):
- Slot0 mask=1111 val=1010 en=1, m_ready=1, start → single beat m_vec=10, done pulse, m_count=1, scan lasts 16 cycles.
- Slot0 mask=0001 val=0001 → beats 1,3,5,…,15 in order, m_count=8.
- Same odd function, m_ready low 5 cycles at first beat → m_vec=1 held stable, no loss or reorder, m_count=8.
- All slots disabled → no m_valid, done after 16 SCAN cycles, m_count=0. Slot with mask=0000 en=1 → 16 beats 0..15.
- abort asserted at vec=6 with a beat pending → IDLE next cycle, m_valid=0, no done. rst_n low mid-scan → all outputs 0 and table cleared immediately.
- QM_DONTCARE_EN: ON cube 1-11, dc cube 0111 → beats 7(m_dc=1), 11(0), 15(0), m_count=2.

Source files
------------

// File: rtl/qm_scan_pkg.sv
// Shared types for the minterm scanner: cube table entry, FSM states and the cube hit test.
package qm_scan_pkg;

    localparam int unsigned CUBE_W = 16;

    typedef logic [CUBE_W-1:0] vec_t;

    // Fields are CUBE_W wide; narrower scanners zero-extend, and a zero mask bit ignores the field bit.
    typedef struct packed {
        vec_t mask;
        vec_t val;
        logic en;
        logic dc;
    } cube_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic cube_hit(input cube_t c, input vec_t v);
        return c.en && (((v ^ c.val) & c.mask) == '0);
    endfunction

endpackage

// File: rtl/qm_cube_match.sv
// Combinational evaluation of the whole term table against one input vector.
module qm_cube_match
    import qm_scan_pkg::*;
#(
    parameter int unsigned N_TERMS = 16
) (
    input  cube_t terms_i [N_TERMS],
    input  vec_t  vec_i,
    output logic  on_hit_o,
    output logic  dc_hit_o
);

    always_comb begin
        on_hit_o = 1'b0;
        dc_hit_o = 1'b0;
        for (int i = 0; i < int'(N_TERMS); i++) begin
            if (cube_hit(terms_i[i], vec_i)) begin
                if (terms_i[i].dc) begin
                    dc_hit_o = 1'b1;
                end else begin
                    on_hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/qm_minterm_scanner.sv
// Sweeps all 2^N_IN input vectors and streams every ON-set minterm of a programmable SOP function.
// Define QM_DONTCARE_EN to add a don't-care set (load_dc in, m_dc out).
module qm_minterm_scanner
    import qm_scan_pkg::*;
#(
    parameter  int unsigned N_IN    = 13,
    parameter  int unsigned N_TERMS = 16,
    localparam int unsigned IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [N_IN-1:0]  load_mask,
    input  logic [N_IN-1:0]  load_val,
    input  logic             load_en,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N_IN-1:0]  m_vec,
    output logic [N_IN:0]    m_count
`ifdef QM_DONTCARE_EN
    ,
    input  logic             load_dc,
    output logic             m_dc
`endif
);

    localparam int unsigned CNT_W = N_IN + 1;

    state_t            state_q, state_d;
    cube_t             table_q [N_TERMS];
    cube_t             table_d [N_TERMS];
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN-1:0]   m_vec_q, m_vec_d;
    logic              m_valid_q, m_valid_d;
    logic [CNT_W-1:0]  m_count_q, m_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_ready_q, load_ready_d;

    cube_t             load_cube;
    vec_t              vec_ext;
    logic              on_hit;
    logic              dc_hit;
    logic              emit;
    logic              hs;
    logic              stall;
    logic              count_ok;
    logic              last_vec;

`ifdef QM_DONTCARE_EN
    logic              m_dc_q, m_dc_d;
    assign count_ok = ~m_dc_q;
`else
    assign count_ok = 1'b1;
`endif

    assign vec_ext  = CUBE_W'(vec_q);
    assign emit     = on_hit | dc_hit;
    assign hs       = m_valid_q & m_ready;
    assign stall    = m_valid_q & ~m_ready;
    assign last_vec = (vec_q == '1);

    always_comb begin
        load_cube      = '0;
        load_cube.mask = CUBE_W'(load_mask);
        load_cube.val  = CUBE_W'(load_val);
        load_cube.en   = load_en;
`ifdef QM_DONTCARE_EN
        load_cube.dc   = load_dc;
`endif
    end

    qm_cube_match #(
        .N_TERMS (N_TERMS)
    ) u_match (
        .terms_i  (table_q),
        .vec_i    (vec_ext),
        .on_hit_o (on_hit),
        .dc_hit_o (dc_hit)
    );

    // Next-state and datapath: output register advances only when not stalled.
    always_comb begin
        state_d   = state_q;
        table_d   = table_q;
        vec_d     = vec_q;
        m_vec_d   = m_vec_q;
        m_valid_d = m_valid_q;
        m_count_d = m_count_q;
`ifdef QM_DONTCARE_EN
        m_dc_d    = m_dc_q;
`endif

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    for (int i = 0; i < int'(N_TERMS); i++) begin
                        if (load_idx == IDX_W'(i)) begin
                            table_d[i] = load_cube;
                        end
                    end
                end
                if (start) begin
                    state_d   = SCAN;
                    vec_d     = '0;
                    m_count_d = '0;
                    m_valid_d = 1'b0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end else begin
                    if (hs && count_ok) begin
                        m_count_d = m_count_q + CNT_W'(1);
                    end
                    if (!stall) begin
                        m_valid_d = emit;
                        if (emit) begin
                            m_vec_d = vec_q;
`ifdef QM_DONTCARE_EN
                            m_dc_d  = ~on_hit;
`endif
                        end
                        if (last_vec) begin
                            state_d = FLUSH;
                        end else begin
                            vec_d = vec_q + N_IN'(1);
                        end
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end else begin
                    if (hs) begin
                        m_valid_d = 1'b0;
                        if (count_ok) begin
                            m_count_d = m_count_q + CNT_W'(1);
                        end
                    end
                    if (!m_valid_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d == SCAN) || (state_d == FLUSH);
        done_d       = (state_d == DONE);
        load_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < int'(N_TERMS); i++) begin
                table_q[i] <= '0;
            end
            vec_q        <= '0;
            m_vec_q      <= '0;
            m_valid_q    <= 1'b0;
            m_count_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
`ifdef QM_DONTCARE_EN
            m_dc_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            table_q      <= table_d;
            vec_q        <= vec_d;
            m_vec_q      <= m_vec_d;
            m_valid_q    <= m_valid_d;
            m_count_q    <= m_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
`ifdef QM_DONTCARE_EN
            m_dc_q       <= m_dc_d;
`endif
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign m_valid    = m_valid_q;
    assign m_vec      = m_vec_q;
    assign m_count    = m_count_q;
`ifdef QM_DONTCARE_EN
    assign m_dc       = m_dc_q;
`endif

endmodule

// File: tb/tb_qm_minterm_scanner.sv
// Scoreboard bench for qm_minterm_scanner (N_IN=4, N_TERMS=4); honours QM_DONTCARE_EN.
module tb_qm_minterm_scanner;

    localparam int unsigned N_IN    = 4;
    localparam int unsigned N_TERMS = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int          NV      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_valid;
    logic             load_ready;
    logic [IDX_W-1:0] load_idx;
    logic [N_IN-1:0]  load_mask;
    logic [N_IN-1:0]  load_val;
    logic             load_en;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             m_valid;
    logic             m_ready;
    logic [N_IN-1:0]  m_vec;
    logic [N_IN:0]    m_count;
`ifdef QM_DONTCARE_EN
    logic             load_dc;
    logic             m_dc;
`endif

    always #5 clk = ~clk;

    qm_minterm_scanner #(
        .N_IN    (N_IN),
        .N_TERMS (N_TERMS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_mask  (load_mask),
        .load_val   (load_val),
        .load_en    (load_en),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_vec      (m_vec),
        .m_count    (m_count)
`ifdef QM_DONTCARE_EN
        ,
        .load_dc    (load_dc),
        .m_dc       (m_dc)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];
    int exp_count;
    int exp_busy;
    int ready_mode = 0;
    int stall_left = 0;

    bit [3:0] md_mask [N_TERMS];
    bit [3:0] md_val  [N_TERMS];
    bit       md_en   [N_TERMS];
    bit       md_dc   [N_TERMS];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int dut_dc();
`ifdef QM_DONTCARE_EN
        return int'(m_dc);
`else
        return 0;
`endif
    endfunction

    // Reference: truth table from the cube list, then ascending emission of ON and DC-only points.
    task automatic build_expect();
        bit on[NV];
        bit dcs[NV];
        exp_count = 0;
        for (int v = 0; v < NV; v++) begin
            on[v]  = 1'b0;
            dcs[v] = 1'b0;
            for (int t = 0; t < int'(N_TERMS); t++) begin
                if (md_en[t] && ((v & int'(md_mask[t])) == (int'(md_val[t]) & int'(md_mask[t])))) begin
                    if (md_dc[t]) dcs[v] = 1'b1;
                    else on[v] = 1'b1;
                end
            end
            if (on[v]) begin
                sb.push_back(v);
                exp_count++;
            end else if (dcs[v]) begin
                sb.push_back(v | 16);
            end
        end
        exp_busy = NV + ((on[NV-1] || dcs[NV-1]) ? 2 : 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slot(input int idx, input int mask, input int val, input bit en, input bit dc);
        load_valid = 1'b1;
        load_idx   = IDX_W'(idx);
        load_mask  = N_IN'(mask);
        load_val   = N_IN'(val);
        load_en    = en;
`ifdef QM_DONTCARE_EN
        load_dc    = dc;
`endif
        md_mask[idx] = 4'(mask);
        md_val[idx]  = 4'(val);
        md_en[idx]   = en;
        md_dc[idx]   = dc;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic kick();
        build_expect();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit chk_busy, input bit bad_load);
        int busy_cnt = 0;
        bit got = 1'b0;
        if (bad_load) begin
            chk("load_ready_in_scan", int'(load_ready), 0);
            load_valid = 1'b1;
            load_idx   = IDX_W'(3);
            load_mask  = '0;
            load_val   = '0;
            load_en    = 1'b1;
        end
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (c == 1) load_valid = 1'b0;
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
        end
        load_valid = 1'b0;
        chk("done_seen", int'(got), 1);
        if (got) begin
            chk("m_count_final", int'(m_count), exp_count);
            chk("sb_drained", sb.size(), 0);
            if (chk_busy) chk("busy_cycles", busy_cnt, exp_busy);
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
            chk("load_ready_idle", int'(load_ready), 1);
            chk("m_count_hold", int'(m_count), exp_count);
        end
        sb.delete();
        tick();
    endtask

    // m_ready driver: 0 always ready, 1 random, 2 stall first beat, 3 never ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (m_valid && stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    initial begin
        bit       pv = 1'b0;
        bit       pr = 1'b0;
        bit       pa = 1'b0;
        bit       prst = 1'b0;
        int       pvec = 0;
        int       e;
        forever begin
            @(negedge clk);
            if (prst && rst_n && pv && !pr && !pa) begin
                chk("stall_valid_held", int'(m_valid), 1);
                chk("stall_vec_held", int'(m_vec), pvec);
            end
            if (rst_n && m_valid && m_ready && !abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(m_vec) | (dut_dc() << 4), -1);
                end else begin
                    e = sb.pop_front();
                    chk("beat", int'(m_vec) | (dut_dc() << 4), e);
                end
            end
            pv   = m_valid;
            pr   = m_ready;
            pa   = abort;
            prst = rst_n;
            pvec = int'(m_vec);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dcount;
        int waited;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_idx   = '0;
        load_mask  = '0;
        load_val   = '0;
        load_en    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        m_ready    = 1'b1;
`ifdef QM_DONTCARE_EN
        load_dc    = 1'b0;
`endif
        for (int t = 0; t < int'(N_TERMS); t++) begin
            md_mask[t] = '0; md_val[t] = '0; md_en[t] = 1'b0; md_dc[t] = 1'b0;
        end
        #23;
        rst_n = 1'b1;
        #1;
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_count", int'(m_count), 0);
        chk("rst_m_vec", int'(m_vec), 0);
        tick();

        // Single minterm 10.
        load_slot(0, 4'b1111, 4'b1010, 1'b1, 1'b0);
        kick();
        wait_done(1'b1, 1'b0);

        // Odd vectors; a write attempted mid-scan must be ignored.
        load_slot(0, 4'b0001, 4'b0001, 1'b1, 1'b0);
        kick();
        wait_done(1'b1, 1'b1);

        // Same function with the first beat stalled five cycles.
        ready_mode = 2;
        stall_left = 5;
        kick();
        wait_done(1'b0, 1'b0);
        ready_mode = 0;

        // Empty function, then a constant-1 cube.
        load_slot(0, 0, 0, 1'b0, 1'b0);
        kick();
        wait_done(1'b1, 1'b0);
        load_slot(2, 4'b0000, 4'b0000, 1'b1, 1'b0);
        kick();
        wait_done(1'b1, 1'b0);
        load_slot(2, 0, 0, 1'b0, 1'b0);

        // Load on the same edge as start uses the new table.
        load_valid = 1'b1;
        load_idx   = IDX_W'(1);
        load_mask  = 4'b1111;
        load_val   = 4'b0101;
        load_en    = 1'b1;
        md_mask[1] = 4'b1111; md_val[1] = 4'b0101; md_en[1] = 1'b1; md_dc[1] = 1'b0;
        kick();
        load_valid = 1'b0;
        wait_done(1'b1, 1'b0);

        // Random tables with random back-pressure.
        ready_mode = 1;
        for (int it = 0; it < 4; it++) begin
            for (int s = 0; s < int'(N_TERMS); s++) begin
`ifdef QM_DONTCARE_EN
                load_slot(s, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
`else
                load_slot(s, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) != 0), 1'b0);
`endif
            end
            kick();
            wait_done(1'b0, 1'b0);
        end
        ready_mode = 0;

`ifdef QM_DONTCARE_EN
        // ON cube 1-11 and DC cube 0111: beats 7(dc), 11, 15.
        load_slot(0, 4'b1011, 4'b1011, 1'b1, 1'b0);
        load_slot(1, 4'b1111, 4'b0111, 1'b1, 1'b1);
        load_slot(2, 0, 0, 1'b0, 1'b0);
        load_slot(3, 0, 0, 1'b0, 1'b0);
        kick();
        wait_done(1'b1, 1'b0);
`endif

        // Abort with beat 6 pending.
        for (int s = 1; s < int'(N_TERMS); s++) load_slot(s, 0, 0, 1'b0, 1'b0);
        load_slot(0, 4'b1111, 4'b0110, 1'b1, 1'b0);
        ready_mode = 3;
        tick();
        kick();
        waited = 0;
        while (!m_valid && waited < 100) begin
            tick();
            waited++;
        end
        chk("abort_pending_valid", int'(m_valid), 1);
        chk("abort_pending_vec", int'(m_vec), 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_m_valid", int'(m_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_load_ready", int'(load_ready), 1);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_m_count", int'(m_count), 0);
        sb.delete();
        ready_mode = 0;
        tick();

        // Asynchronous reset mid-scan clears outputs and the table.
        load_slot(3, 4'b0000, 4'b0000, 1'b1, 1'b0);
        kick();
        for (int c = 0; c < 6; c++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_m_count", int'(m_count), 0);
        chk("midrst_m_vec", int'(m_vec), 0);
        sb.delete();
        for (int t = 0; t < int'(N_TERMS); t++) begin
            md_mask[t] = '0; md_val[t] = '0; md_en[t] = 1'b0; md_dc[t] = 1'b0;
        end
        #14;
        rst_n = 1'b1;
        tick();
        kick();
        wait_done(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
